// File: rtl/serial_cnt_loader.sv
// rtl/serial_cnt_loader.sv - serial-init loader and count driver for a saturating up-counter
//
// Purpose:
//   Waits for a start bit on serin, shifts in an INIT_W-bit value MSB first,
//   loads it into the downstream counter with a one-cycle ld_cnt pulse, then
//   issues cnt on every tick until the counter reports co, and finally pulses
//   done. ticks reports how many cnt pulses were issued in the frame.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset
//   serin   in   serial line: start bit, then INIT_W data bits MSB first
//   tick    in   count enable, one cnt per cycle while counting
//   co      in   carry-out (all ones) from the downstream counter
//   ld_cnt  out  load strobe to the counter
//   cnt     out  count strobe to the counter
//   init0   out  value loaded into the counter
//   busy    out  high in every state except IDLE
//   done    out  one-cycle completion pulse
//   ticks   out  cnt pulses issued in the current or last frame
//
// INIT_W must be at least 2.

module serial_cnt_loader #(
    parameter int   INIT_W    = 3,
    parameter logic START_LVL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serin,
    input  logic              tick,
    input  logic              co,
    output logic              ld_cnt,
    output logic              cnt,
    output logic [INIT_W-1:0] init0,
    output logic              busy,
    output logic              done,
    output logic [INIT_W-1:0] ticks
);

    localparam int            BW       = $clog2(INIT_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(INIT_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_LOAD,
        S_COUNT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    // Only the first INIT_W-1 bits need storing; the last bit goes straight
    // from serin into init0 on the LOAD transition.
    logic [INIT_W-2:0]   r_shift;
    logic [BW-1:0]       r_bitcnt;
    logic [INIT_W-1:0]   r_init0;
    logic [INIT_W-1:0]   r_ticks;
    logic [INIT_W-1:0]   w_shift_next;
    logic                w_last_bit;

    assign w_shift_next = {r_shift, serin};
    assign w_last_bit   = (r_bitcnt == LAST_BIT);
    assign init0        = r_init0;
    assign ticks        = r_ticks;

    always_comb begin
        w_next = r_state;
        ld_cnt = 1'b0;
        cnt    = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (serin == START_LVL) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last_bit) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                ld_cnt = 1'b1;
                w_next = S_COUNT;
            end
            S_COUNT: begin
                // Never count into a counter that is already saturated.
                cnt = tick & ~co;
                if (co) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_init0  <= '0;
            r_ticks  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (serin == START_LVL) begin
                        r_bitcnt <= '0;
                        r_ticks  <= '0;
                    end
                end
                S_SHIFT: begin
                    r_shift  <= w_shift_next[INIT_W-2:0];
                    r_bitcnt <= r_bitcnt + BW'(1);
                    // init0 changes only here so it stays stable from LOAD
                    // until the next frame's LOAD.
                    if (w_last_bit) begin
                        r_init0 <= w_shift_next;
                    end
                end
                S_COUNT: begin
                    if (cnt) begin
                        r_ticks <= r_ticks + INIT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
